// File: rtl/ex_mdu_if.sv
// EX stage <-> multiply/divide unit: request, flush, operands and busy/done/result.
interface ex_mdu_if #(
  parameter int XLEN = 32
);
  logic            pipe_flush;
  logic            mdu_start;
  logic [2:0]      mdu_op;
  logic            mdu_word;
  logic [XLEN-1:0] mdu_src1;
  logic [XLEN-1:0] mdu_src2;
  logic            mdu_busy;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_res;

  modport master (
    output pipe_flush, mdu_start, mdu_op, mdu_word, mdu_src1, mdu_src2,
    input  mdu_busy, mdu_done, mdu_res
  );
  modport slave (
    input  pipe_flush, mdu_start, mdu_op, mdu_word, mdu_src1, mdu_src2,
    output mdu_busy, mdu_done, mdu_res
  );
endinterface

// File: rtl/ex_mdu.sv
// Iterative RV M-extension unit: shift-add multiply (MUL_BITS/cycle) and restoring
// divide (1 bit/cycle) on operand magnitudes, with sign fix-up in a final FIX cycle.
module ex_mdu #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2,
  parameter int W_EN     = 0
) (
  input logic     clk,
  input logic     rst_n,
  ex_mdu_if.slave mdu
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int PW    = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic             flush;
  logic             start;
  logic [2:0]       op;
  logic [XLEN-1:0]  src1;
  logic [XLEN-1:0]  src2;

  logic [2:0]       op_q;
  logic             word_q;
  logic             neg_q;
  logic             rneg_q;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [XLEN-1:0]  mplier;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  dvs;
  logic [XLEN-1:0]  res;

  assign flush = mdu.pipe_flush;
  assign start = mdu.mdu_start;
  assign op    = mdu.mdu_op;
  assign src1  = mdu.mdu_src1;
  assign src2  = mdu.mdu_src2;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    logic [XLEN-1:0] r;
    r       = {XLEN{x[31]}};
    r[31:0] = x;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                input logic neg, input logic word);
    logic [XLEN-1:0] r;
    logic [31:0]     lo;
    lo = neg ? -x[31:0] : x[31:0];
    r  = '0;
    if (word) r[31:0] = lo;
    else      r = neg ? -x : x;
    return r;
  endfunction

  function automatic logic [PW-1:0] part_prod(input logic [PW-1:0] m,
                                              input logic [MUL_BITS-1:0] d);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < MUL_BITS; i++)
      if (d[i]) r = r + (m << i);
    return r;
  endfunction

  // Request decode: operand reduction, magnitudes and fast-path detection
  logic             is_div, word_in, s1_signed, s2_signed, sign1, sign2;
  logic             div_zero, div_ovf, fast, accept;
  logic [XLEN-1:0]  mag1, mag2, dvd_red, fast_res;
  logic [CNT_W-1:0] cnt_init;

  always_comb begin
    is_div    = op[2];
    word_in   = (W_EN != 0) && mdu.mdu_word && (is_div || op == 3'b000);
    s1_signed = is_div ? ~op[0] : ~(op[1] & op[0]);
    s2_signed = is_div ? ~op[0] : ~op[1];
    sign1     = s1_signed && (word_in ? src1[31] : src1[XLEN-1]);
    sign2     = s2_signed && (word_in ? src2[31] : src2[XLEN-1]);
    mag1      = magnitude(src1, sign1, word_in);
    mag2      = magnitude(src2, sign2, word_in);
    dvd_red   = word_in ? sext32(src1[31:0]) : src1;
    if (word_in) begin
      div_zero = src2[31:0] == 32'd0;
      div_ovf  = src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF;
    end else begin
      div_zero = src2 == '0;
      div_ovf  = src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1;
    end
    div_ovf = div_ovf && !op[0];
    fast    = is_div && (div_zero || div_ovf);
    // Zero divisor dominates the overflow case; op[1] selects remainder.
    if (div_zero) fast_res = op[1] ? dvd_red : '1;
    else          fast_res = op[1] ? '0 : dvd_red;
    if (is_div) cnt_init = word_in ? CNT_W'(31) : CNT_W'(XLEN - 1);
    else        cnt_init = word_in ? CNT_W'(32 / MUL_BITS - 1) : CNT_W'(XLEN / MUL_BITS - 1);
    accept = start && !flush && (state == IDLE || state == DONE);
  end

  // CALC step: one restoring-divide bit
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_sub;
  logic            rem_ge;

  always_comb begin
    rem_sh  = {rem, quo[XLEN-1]};
    rem_ge  = rem_sh >= {1'b0, dvs};
    rem_sub = rem_sh[XLEN-1:0] - dvs;
  end

  // FIX: sign correction and result selection
  logic [PW-1:0]   prod;
  logic [XLEN-1:0] q_s, r_s, fix_res;

  always_comb begin
    prod = neg_q ? -acc : acc;
    q_s  = neg_q ? -quo : quo;
    r_s  = rneg_q ? -rem : rem;
    case (op_q)
      3'b000:                 fix_res = word_q ? sext32(prod[31:0]) : prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[PW-1:XLEN];
      3'b100, 3'b101:         fix_res = word_q ? sext32(q_s[31:0]) : q_s;
      default:                fix_res = word_q ? sext32(r_s[31:0]) : r_s;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = accept ? (fast ? DONE : CALC) : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      word_q <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      res    <= '0;
    end else if (accept) begin
      op_q   <= op;
      word_q <= word_in;
      neg_q  <= sign1 ^ sign2;
      rneg_q <= sign1;
      cnt    <= cnt_init;
      acc    <= '0;
      mcand  <= PW'(mag1);
      mplier <= mag2;
      // Word dividends are left-aligned so the MSB feeds the remainder first.
      quo    <= word_in ? (mag1 << (XLEN - 32)) : mag1;
      rem    <= '0;
      dvs    <= mag2;
      if (fast) res <= fast_res;
    end else if (state == CALC) begin
      cnt <= cnt - CNT_W'(1);
      if (op_q[2]) begin
        rem <= rem_ge ? rem_sub : rem_sh[XLEN-1:0];
        quo <= {quo[XLEN-2:0], rem_ge};
      end else begin
        acc    <= acc + part_prod(mcand, mplier[MUL_BITS-1:0]);
        mcand  <= mcand << MUL_BITS;
        mplier <= mplier >> MUL_BITS;
      end
    end else if (state == FIX && !flush) begin
      res <= fix_res;
    end
  end

  assign mdu.mdu_busy = (state == CALC) || (state == FIX);
  assign mdu.mdu_done = (state == DONE);
  assign mdu.mdu_res  = res;
endmodule

// File: tb/tb_ex_mdu.sv
// Bench for ex_mdu: three instances (32-bit, 64-bit with word ops, 64-bit without) share
// one stimulus bus; directed table, hand sequences and random ops against a plain model.
module tb_ex_mdu;
  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        start;
  logic [2:0]  op;
  logic        word;
  logic [63:0] a, b;
  int          sel;
  int          total = 0;
  int          bad   = 0;

  int xl_of[3]  = '{32, 64, 64};
  int mb_of[3]  = '{2, 4, 1};
  bit wen_of[3] = '{1'b0, 1'b1, 1'b0};

  ex_mdu_if #(.XLEN(32)) if0 ();
  ex_mdu_if #(.XLEN(64)) if1 ();
  ex_mdu_if #(.XLEN(64)) if2 ();

  assign if0.pipe_flush = flush;
  assign if0.mdu_start  = start && (sel == 0);
  assign if0.mdu_op     = op;
  assign if0.mdu_word   = word;
  assign if0.mdu_src1   = a[31:0];
  assign if0.mdu_src2   = b[31:0];
  assign if1.pipe_flush = flush;
  assign if1.mdu_start  = start && (sel == 1);
  assign if1.mdu_op     = op;
  assign if1.mdu_word   = word;
  assign if1.mdu_src1   = a;
  assign if1.mdu_src2   = b;
  assign if2.pipe_flush = flush;
  assign if2.mdu_start  = start && (sel == 2);
  assign if2.mdu_op     = op;
  assign if2.mdu_word   = word;
  assign if2.mdu_src1   = a;
  assign if2.mdu_src2   = b;

  ex_mdu #(.XLEN(32), .MUL_BITS(2), .W_EN(0)) u0 (.clk(clk), .rst_n(rst_n), .mdu(if0));
  ex_mdu #(.XLEN(64), .MUL_BITS(4), .W_EN(1)) u1 (.clk(clk), .rst_n(rst_n), .mdu(if1));
  ex_mdu #(.XLEN(64), .MUL_BITS(1), .W_EN(0)) u2 (.clk(clk), .rst_n(rst_n), .mdu(if2));

  logic        busy_m, done_m;
  logic [63:0] res_m;

  always_comb begin
    busy_m = if0.mdu_busy;
    done_m = if0.mdu_done;
    res_m  = {32'd0, if0.mdu_res};
    if (sel == 1) begin
      busy_m = if1.mdu_busy; done_m = if1.mdu_done; res_m = if1.mdu_res;
    end else if (sel == 2) begin
      busy_m = if2.mdu_busy; done_m = if2.mdu_done; res_m = if2.mdu_res;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s #%0d: got %h, expected %h", nm, tag, got, exp);
    end
  endtask

  // Reference: results straight from the RV M-extension arithmetic on wide signed integers.
  task automatic ref_model(input int s, input logic [2:0] o, input bit w_in,
                           input logic [63:0] x, input logic [63:0] y,
                           output logic [63:0] r, output int lat);
    int xl, w;
    bit we;
    logic signed [129:0] m, half, ua, ub, sa, sb, p, q, rm, v;
    xl   = xl_of[s];
    we   = wen_of[s] && w_in && (o[2] || o == 3'b000);
    w    = we ? 32 : xl;
    m    = 130'sd1;
    m    = m << w;
    half = m >>> 1;
    ua   = {66'd0, x} & (m - 130'sd1);
    ub   = {66'd0, y} & (m - 130'sd1);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    if (!o[2]) begin
      case (o[1:0])
        2'b00, 2'b01: p = sa * sb;
        2'b10:        p = sa * ub;
        default:      p = ua * ub;
      endcase
      v   = (o[1:0] == 2'b00) ? p : (p >>> w);
      lat = w / mb_of[s] + 2;
    end else begin
      if (ub == 130'sd0) begin
        q = m - 130'sd1; rm = ua; lat = 1;
      end else if (!o[0] && sa == -half && sb == -130'sd1) begin
        q = ua; rm = 130'sd0; lat = 1;
      end else begin
        lat = w + 2;
        if (!o[0]) begin q = sa / sb; rm = sa % sb; end
        else       begin q = ua / ub; rm = ua % ub; end
      end
      v = o[1] ? rm : q;
    end
    v = v & (m - 130'sd1);
    if (w < xl && v >= half) v = v - m;
    r = v[63:0];
    if (xl == 32) r[63:32] = 32'd0;
  endtask

  task automatic run_op(input int s, input logic [2:0] o, input bit w_in,
                        input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] er, input int el, input int tag);
    int cyc;
    bit got;
    sel = s; op = o; word = w_in; a = x; b = y; start = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1 && el > 1) chk("busy", tag, 64'(busy_m), 64'd1);
      if (done_m) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL timeout #%0d: no done after %0d cycles, expected at %0d", tag, cyc, el);
    end else begin
      chk("latency", tag, 64'(cyc), 64'(el));
      chk("result", tag, res_m, er);
      chk("busy_in_done", tag, 64'(busy_m), 64'd0);
    end
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return {$urandom, 32'h8000_0000};
      4:       return 64'($urandom_range(0, 9));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  typedef struct {
    int          s;
    logic [2:0]  op;
    bit          word;
    logic [63:0] a, b, r;
    int          lat;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int cyc;
    bit got;

    tbl[0]  = '{0, 3'b000, 1'b0, 64'h7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 18};
    tbl[1]  = '{0, 3'b011, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 18};
    tbl[2]  = '{0, 3'b001, 1'b0, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 18};
    tbl[3]  = '{0, 3'b010, 1'b0, 64'hFFFF_FFFF, 64'h2, 64'hFFFF_FFFF, 18};
    tbl[4]  = '{0, 3'b100, 1'b0, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFD, 34};
    tbl[5]  = '{0, 3'b110, 1'b0, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFF, 34};
    tbl[6]  = '{0, 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 34};
    tbl[7]  = '{0, 3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 34};
    tbl[8]  = '{0, 3'b100, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF, 1};
    tbl[9]  = '{0, 3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1};
    tbl[10] = '{0, 3'b100, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1};
    tbl[11] = '{0, 3'b110, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 1};
    tbl[12] = '{1, 3'b100, 1'b1, 64'h1_FFFF_FFF8, 64'h2, 64'hFFFF_FFFF_FFFF_FFFC, 34};
    tbl[13] = '{1, 3'b000, 1'b1, 64'h1_0000, 64'h1_0000, 64'h0, 10};
    tbl[14] = '{2, 3'b100, 1'b1, 64'h1_FFFF_FFF8, 64'h2, 64'h0000_0000_FFFF_FFFC, 66};
    tbl[15] = '{1, 3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 18};
    tbl[16] = '{1, 3'b111, 1'b1, 64'h0000_1234_8000_0000, 64'hFFFF_0000_0000_0000,
                64'hFFFF_FFFF_8000_0000, 1};
    tbl[17] = '{2, 3'b000, 1'b1, 64'h1_0000_0000, 64'h3, 64'h3_0000_0000, 66};
    tbl[18] = '{1, 3'b001, 1'b1, 64'h100_0000_0000, 64'h100_0000_0000, 64'h1_0000, 18};

    rst_n = 1'b0; flush = 1'b0; start = 1'b0; op = 3'b000; word = 1'b0;
    a = '0; b = '0; sel = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy0", 0, 64'(if0.mdu_busy), 64'd0);
    chk("reset_done0", 0, 64'(if0.mdu_done), 64'd0);
    chk("reset_res0", 0, 64'(if0.mdu_res), 64'd0);
    chk("reset_busy1", 1, 64'(if1.mdu_busy), 64'd0);
    chk("reset_done1", 1, 64'(if1.mdu_done), 64'd0);
    chk("reset_res1", 1, if1.mdu_res, 64'd0);
    chk("reset_res2", 2, if2.mdu_res, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 19; i++)
      run_op(tbl[i].s, tbl[i].op, tbl[i].word, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].lat, i);

    // Flush mid-divide, with a start in the same cycle that must be dropped.
    run_op(0, 3'b000, 1'b0, 64'h7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 18, 100);
    sel = 0; op = 3'b100; a = 64'd100; b = 64'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush_pre_busy", 101, 64'(busy_m), 64'd1);
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 3'b000; a = 64'd3; b = 64'd3;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush_busy", 101, 64'(busy_m), 64'd0);
    chk("flush_done", 101, 64'(done_m), 64'd0);
    chk("flush_res", 101, res_m, 64'hFFFF_FFEB);
    run_op(0, 3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 34, 102);

    // Back-to-back start in the DONE cycle, plus an ignored start while busy.
    run_op(0, 3'b000, 1'b0, 64'd3, 64'd5, 64'd15, 18, 103);
    op = 3'b000; a = 64'd6; b = 64'd7; start = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == 3) begin
        chk("b2b_hold", 104, res_m, 64'd15);
        op = 3'b100; a = 64'd9; b = 64'd0; start = 1'b1;
      end
      if (cyc == 4) start = 1'b0;
      if (done_m) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL timeout #104: back-to-back MUL never completed");
    end else begin
      chk("b2b_latency", 104, 64'(cyc), 64'd18);
      chk("b2b_result", 104, res_m, 64'd42);
    end

    for (int i = 0; i < 240; i++) begin
      int          s, el;
      logic [2:0]  o;
      bit          w;
      logic [63:0] x, y, er;
      s = i % 3;
      o = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      x = pick();
      y = pick();
      ref_model(s, o, w, x, y, er, el);
      run_op(s, o, w, x, y, er, el, 1000 + i);
    end

    // Asynchronous reset in the middle of a 64-bit divide.
    run_op(1, 3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 18, 200);
    sel = 1; op = 3'b101; word = 1'b0; a = 64'd1000; b = 64'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pre_busy", 201, 64'(busy_m), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 202, 64'(busy_m), 64'd0);
    chk("rst_done", 202, 64'(done_m), 64'd0);
    chk("rst_res", 202, res_m, 64'd0);
    chk("rst_res0", 202, 64'(if0.mdu_res), 64'd0);
    chk("rst_res2", 202, if2.mdu_res, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1, 3'b101, 1'b0, 64'd1000, 64'd3, 64'd333, 66, 203);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
